// File: rtl/id_hazard_pkg.sv
// Shared constants for the ID-stage operand bypass and long-latency hazard scoreboard.
package id_hazard_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;

  localparam int CAUSE_FWD_NOT_READY = 0;
  localparam int CAUSE_SB_RAW        = 1;
  localparam int CAUSE_WAW           = 2;
  localparam int CAUSE_W             = 3;

  localparam int FWD_EX = 0;
  localparam int FWD_ME = 1;
  localparam int FWD_WB = 2;

  // Field order matches the stall_cause bit indices above.
  typedef struct packed {
    logic waw;
    logic sbRaw;
    logic fwdNotReady;
  } stall_cause_t;

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// Bus between the ID stage / pipeline and the hazard scoreboard.
// HAZARD_STATS_EN adds the per-cause stall counter outputs.
interface id_hazard_scoreboard_if
  import id_hazard_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int NUM_SRC = 3,
  parameter int XLEN    = XLEN_DEF,
  parameter int AW      = AW_DEF
);
  logic [NUM_FWD-1:0]      fwd_valid;
  logic [NUM_FWD*AW-1:0]   fwd_dest;
  logic [NUM_FWD-1:0]      fwd_ready;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic [NUM_SRC-1:0]      src_en;
  logic [NUM_SRC*AW-1:0]   src_addr;
  logic [NUM_SRC*XLEN-1:0] rf_rdata;
  logic [NUM_SRC*XLEN-1:0] src_value;
  logic                    id_valid;
  logic [AW-1:0]           id_dest;
  logic                    id_long;
  logic                    issue_fire;
  logic                    lw_valid;
  logic [AW-1:0]           lw_dest;
  logic [XLEN-1:0]         lw_data;
  logic                    stall;
  logic [2:0]              stall_cause;
`ifdef HAZARD_STATS_EN
  logic [31:0]             stat_fwd_stall;
  logic [31:0]             stat_sb_stall;
  logic [31:0]             stat_waw_stall;
`endif

  modport master (
    output fwd_valid, fwd_dest, fwd_ready, fwd_data,
    output src_en, src_addr, rf_rdata,
    output id_valid, id_dest, id_long, issue_fire,
    output lw_valid, lw_dest, lw_data,
    input  src_value, stall, stall_cause
`ifdef HAZARD_STATS_EN
    , input stat_fwd_stall, stat_sb_stall, stat_waw_stall
`endif
  );

  modport slave (
    input  fwd_valid, fwd_dest, fwd_ready, fwd_data,
    input  src_en, src_addr, rf_rdata,
    input  id_valid, id_dest, id_long, issue_fire,
    input  lw_valid, lw_dest, lw_data,
    output src_value, stall, stall_cause
`ifdef HAZARD_STATS_EN
    , output stat_fwd_stall, stat_sb_stall, stat_waw_stall
`endif
  );

endinterface

// File: rtl/operand_resolve.sv
// Resolves one source operand: prioritised forward mux, long-writeback bypass,
// scoreboard RAW check, then regfile data.
module operand_resolve
  import id_hazard_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int XLEN    = XLEN_DEF,
  parameter int AW      = AW_DEF
) (
  input  logic                    i_srcEn,
  input  logic [AW-1:0]           i_srcAddr,
  input  logic [XLEN-1:0]         i_rfData,
  input  logic [NUM_FWD-1:0]      i_fwdValid,
  input  logic [NUM_FWD*AW-1:0]   i_fwdDest,
  input  logic [NUM_FWD-1:0]      i_fwdReady,
  input  logic [NUM_FWD*XLEN-1:0] i_fwdData,
  input  logic                    i_lwValid,
  input  logic [AW-1:0]           i_lwDest,
  input  logic [XLEN-1:0]         i_lwData,
  input  logic                    i_pendNz,
  output logic [XLEN-1:0]         o_value,
  output logic                    o_fwdNotReady,
  output logic                    o_sbRaw
);
  logic            w_hit;
  logic            w_hitReady;
  logic [XLEN-1:0] w_hitData;

  // Walk from oldest to youngest so the youngest matching producer wins,
  // including its ready flag: an unready young match hides any older one.
  always_comb begin
    w_hit      = 1'b0;
    w_hitReady = 1'b0;
    w_hitData  = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (i_fwdValid[i] && (i_fwdDest[i*AW +: AW] == i_srcAddr)) begin
        w_hit      = 1'b1;
        w_hitReady = i_fwdReady[i];
        w_hitData  = i_fwdData[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    o_value       = '0;
    o_fwdNotReady = 1'b0;
    o_sbRaw       = 1'b0;
    if (i_srcEn && (i_srcAddr != '0)) begin
      if (w_hit) begin
        if (w_hitReady) begin
          o_value = w_hitData;
        end else begin
          o_fwdNotReady = 1'b1;
        end
      end else if (i_lwValid && (i_lwDest == i_srcAddr)) begin
        o_value = i_lwData;
      end else if (i_pendNz) begin
        o_sbRaw = 1'b1;
      end else begin
        o_value = i_rfData;
      end
    end
  end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage operand bypass and per-register scoreboard of in-flight long-latency ops.
// Build macro HAZARD_STATS_EN adds 32-bit per-cause stall counters.
module id_hazard_scoreboard
  import id_hazard_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int NUM_SRC = 3,
  parameter int XLEN    = XLEN_DEF,
  parameter int AW      = AW_DEF,
  parameter int PEND_W  = 2
) (
  input logic clk,
  input logic reset,
  id_hazard_scoreboard_if.slave bus
);
  localparam int NUM_REGS = 1 << AW;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0]   r_pending [NUM_REGS];
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic [XLEN-1:0]     w_values [NUM_SRC];
  logic                w_srcFnr [NUM_SRC];
  logic                w_srcSb  [NUM_SRC];
  logic                w_anyFnr;
  logic                w_anySb;
  logic [PEND_W-1:0]   w_destPend;
  logic                w_lwHitsDest;
  logic                w_waw;
  stall_cause_t        w_cause;

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    logic [AW-1:0] w_addr;
    logic          w_pendNz;
    assign w_addr   = bus.src_addr[j*AW +: AW];
    assign w_pendNz = (r_pending[w_addr] != '0);

    operand_resolve #(
      .NUM_FWD (NUM_FWD),
      .XLEN    (XLEN),
      .AW      (AW)
    ) u_resolve (
      .i_srcEn       (bus.src_en[j]),
      .i_srcAddr     (w_addr),
      .i_rfData      (bus.rf_rdata[j*XLEN +: XLEN]),
      .i_fwdValid    (bus.fwd_valid),
      .i_fwdDest     (bus.fwd_dest),
      .i_fwdReady    (bus.fwd_ready),
      .i_fwdData     (bus.fwd_data),
      .i_lwValid     (bus.lw_valid),
      .i_lwDest      (bus.lw_dest),
      .i_lwData      (bus.lw_data),
      .i_pendNz      (w_pendNz),
      .o_value       (w_values[j]),
      .o_fwdNotReady (w_srcFnr[j]),
      .o_sbRaw       (w_srcSb[j])
    );
  end

  always_comb begin
    bus.src_value = '0;
    w_anyFnr      = 1'b0;
    w_anySb       = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      bus.src_value[j*XLEN +: XLEN] = w_values[j];
      w_anyFnr = w_anyFnr | w_srcFnr[j];
      w_anySb  = w_anySb  | w_srcSb[j];
    end
  end

  // A retiring long op to the same register frees the WAW slot this cycle,
  // but a long op can never be accepted onto a saturated counter.
  assign w_destPend   = r_pending[bus.id_dest];
  assign w_lwHitsDest = bus.lw_valid && (bus.lw_dest == bus.id_dest);
  assign w_waw        = (bus.id_dest != '0) &&
                        (((w_destPend != '0) && !w_lwHitsDest) ||
                         (bus.id_long && (w_destPend == PEND_MAX)));

  always_comb begin
    w_cause = '0;
    if (bus.id_valid) begin
      w_cause.waw         = w_waw;
      w_cause.sbRaw       = w_anySb;
      w_cause.fwdNotReady = w_anyFnr;
    end
  end

  assign bus.stall_cause = w_cause;
  assign bus.stall       = |w_cause;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_inc[r] = bus.issue_fire && bus.id_long && (bus.id_dest == AW'(r)) && (r != 0);
      w_dec[r] = bus.lw_valid && (bus.lw_dest == AW'(r));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_pending[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_inc[r] && !w_dec[r] && (r_pending[r] != PEND_MAX)) begin
          r_pending[r] <= r_pending[r] + PEND_W'(1);
        end else if (w_dec[r] && !w_inc[r] && (r_pending[r] != '0)) begin
          r_pending[r] <= r_pending[r] - PEND_W'(1);
        end
      end
    end
  end

  // Protocol checks: no issue under stall, no retire without a pending op,
  // no long issue onto a full counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.issue_fire && bus.stall));
      assert (!(bus.lw_valid && (r_pending[bus.lw_dest] == '0) && !w_inc[bus.lw_dest]));
      assert (!(w_inc[bus.id_dest] && !w_dec[bus.id_dest] && (r_pending[bus.id_dest] == PEND_MAX)));
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_statFwd;
  logic [31:0] r_statSb;
  logic [31:0] r_statWaw;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_statFwd <= '0;
      r_statSb  <= '0;
      r_statWaw <= '0;
    end else begin
      if (bus.stall && w_cause.fwdNotReady) r_statFwd <= r_statFwd + 32'd1;
      if (bus.stall && w_cause.sbRaw)       r_statSb  <= r_statSb + 32'd1;
      if (bus.stall && w_cause.waw)         r_statWaw <= r_statWaw + 32'd1;
    end
  end

  assign bus.stat_fwd_stall = r_statFwd;
  assign bus.stat_sb_stall  = r_statSb;
  assign bus.stat_waw_stall = r_statWaw;
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Bench for id_hazard_scoreboard: vector table, multi-cycle scoreboard sequences,
// and random traffic against a behavioural model of the forwarding/scoreboard rules.
module tb_id_hazard_scoreboard;
  import id_hazard_pkg::*;

  localparam int NF   = 3;
  localparam int NS   = 3;
  localparam int XL   = 32;
  localparam int AWB  = 5;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_hazard_scoreboard_if #(.NUM_FWD(NF), .NUM_SRC(NS), .XLEN(XL), .AW(AWB)) bus ();

  id_hazard_scoreboard #(
    .NUM_FWD (NF),
    .NUM_SRC (NS),
    .XLEN    (XL),
    .AW      (AWB),
    .PEND_W  (PW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nCompared = 0;
  int nFailed   = 0;

  int          modelPend [32];
  logic [31:0] expVal [NS];
  logic [2:0]  expCause;
  logic        expStall;
`ifdef HAZARD_STATS_EN
  int modelStatFwd = 0;
  int modelStatSb  = 0;
  int modelStatWaw = 0;
`endif

  typedef struct {
    string            name;
    logic [NF-1:0]    fv;
    logic [NF-1:0]    fr;
    logic [NF-1:0][4:0]  fd;
    logic [NF-1:0][31:0] fdat;
    int               en;
    int               addr;
    logic [31:0]      rf;
    logic [31:0]      expV;
    int               expS;
    int               expC;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(string name, logic [2:0] fv, logic [2:0] fr,
                                 int d0, int d1, int d2,
                                 logic [31:0] x0, logic [31:0] x1, logic [31:0] x2,
                                 int en, int addr, logic [31:0] rf,
                                 logic [31:0] expV, int expS, int expC);
    vec_t v;
    v.name = name;
    v.fv = fv;
    v.fr = fr;
    v.fd[FWD_EX] = 5'(d0);
    v.fd[FWD_ME] = 5'(d1);
    v.fd[FWD_WB] = 5'(d2);
    v.fdat[FWD_EX] = x0;
    v.fdat[FWD_ME] = x1;
    v.fdat[FWD_WB] = x2;
    v.en = en;
    v.addr = addr;
    v.rf = rf;
    v.expV = expV;
    v.expS = expS;
    v.expC = expC;
    return v;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    nCompared++;
    if (act !== req) begin
      nFailed++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic clearInputs();
    bus.fwd_valid  = '0;
    bus.fwd_dest   = '0;
    bus.fwd_ready  = '0;
    bus.fwd_data   = '0;
    bus.src_en     = '0;
    bus.src_addr   = '0;
    bus.rf_rdata   = '0;
    bus.id_valid   = 1'b0;
    bus.id_dest    = '0;
    bus.id_long    = 1'b0;
    bus.issue_fire = 1'b0;
    bus.lw_valid   = 1'b0;
    bus.lw_dest    = '0;
    bus.lw_data    = '0;
  endtask

  task automatic setFwd(input int i, input int v, input int d, input int r, input logic [31:0] data);
    bus.fwd_valid[i]          = (v != 0);
    bus.fwd_dest[i*AWB +: AWB] = 5'(d);
    bus.fwd_ready[i]          = (r != 0);
    bus.fwd_data[i*XL +: XL]  = data;
  endtask

  task automatic setSrc(input int j, input int en, input int a, input logic [31:0] rf);
    bus.src_en[j]              = (en != 0);
    bus.src_addr[j*AWB +: AWB] = 5'(a);
    bus.rf_rdata[j*XL +: XL]   = rf;
  endtask

  task automatic setId(input int valid, input int dest, input int isLong, input int fire);
    bus.id_valid   = (valid != 0);
    bus.id_dest    = 5'(dest);
    bus.id_long    = (isLong != 0);
    bus.issue_fire = (fire != 0);
  endtask

  task automatic setLw(input int v, input int d, input logic [31:0] data);
    bus.lw_valid = (v != 0);
    bus.lw_dest  = 5'(d);
    bus.lw_data  = data;
  endtask

  // Reference: youngest matching producer decides; then long writeback; then
  // the pending count; then the regfile.
  task automatic modelEval();
    bit fnr, sb, waw;
    int hit, a, dp;
    fnr = 0;
    sb  = 0;
    for (int j = 0; j < NS; j++) begin
      expVal[j] = '0;
      a = int'(bus.src_addr[j*AWB +: AWB]);
      if (bus.src_en[j] && a != 0) begin
        hit = -1;
        for (int i = 0; i < NF; i++) begin
          if (hit < 0 && bus.fwd_valid[i] && int'(bus.fwd_dest[i*AWB +: AWB]) == a) hit = i;
        end
        if (hit >= 0) begin
          if (bus.fwd_ready[hit]) expVal[j] = bus.fwd_data[hit*XL +: XL];
          else fnr = 1;
        end else if (bus.lw_valid && int'(bus.lw_dest) == a) begin
          expVal[j] = bus.lw_data;
        end else if (modelPend[a] > 0) begin
          sb = 1;
        end else begin
          expVal[j] = bus.rf_rdata[j*XL +: XL];
        end
      end
    end
    dp  = modelPend[int'(bus.id_dest)];
    waw = (bus.id_dest != 0) &&
          ((dp > 0 && !(bus.lw_valid && bus.lw_dest == bus.id_dest)) ||
           (bus.id_long && dp == PMAX));
    expCause = '0;
    if (bus.id_valid) begin
      expCause[CAUSE_WAW]           = waw;
      expCause[CAUSE_SB_RAW]        = sb;
      expCause[CAUSE_FWD_NOT_READY] = fnr;
    end
    expStall = |expCause;
  endtask

  task automatic modelUpdate();
    bit inc, dec;
    if (reset) begin
      for (int r = 0; r < 32; r++) modelPend[r] = 0;
`ifdef HAZARD_STATS_EN
      modelStatFwd = 0;
      modelStatSb  = 0;
      modelStatWaw = 0;
`endif
    end else begin
`ifdef HAZARD_STATS_EN
      modelEval();
      if (expCause[CAUSE_FWD_NOT_READY]) modelStatFwd++;
      if (expCause[CAUSE_SB_RAW])        modelStatSb++;
      if (expCause[CAUSE_WAW])           modelStatWaw++;
`endif
      for (int r = 1; r < 32; r++) begin
        inc = bus.issue_fire && bus.id_long && int'(bus.id_dest) == r;
        dec = bus.lw_valid && int'(bus.lw_dest) == r;
        if (inc && !dec && modelPend[r] < PMAX) modelPend[r] = modelPend[r] + 1;
        if (dec && !inc && modelPend[r] > 0)    modelPend[r] = modelPend[r] - 1;
      end
    end
  endtask

  task automatic cycle();
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    clearInputs();
    setId(1, 0, 0, 0);
    for (int i = 0; i < NF; i++) setFwd(i, int'(v.fv[i]), int'(v.fd[i]), int'(v.fr[i]), v.fdat[i]);
    setSrc(0, v.en, v.addr, v.rf);
  endtask

  task automatic checkConst(input string name, input logic [31:0] v0, input int s, input int c);
    compare({name, "_value"}, bus.src_value[31:0], v0);
    compare({name, "_stall"}, 32'(bus.stall), s);
    compare({name, "_cause"}, 32'(bus.stall_cause), c);
  endtask

  task automatic checkOutput(input string name);
    modelEval();
    for (int j = 0; j < NS; j++) begin
      compare($sformatf("%s_value%0d", name, j), bus.src_value[j*XL +: XL], expVal[j]);
    end
    compare({name, "_stall"}, 32'(bus.stall), 32'(expStall));
    compare({name, "_cause"}, 32'(bus.stall_cause), 32'(expCause));
  endtask

  initial begin
    int r;
    clearInputs();
    for (int k = 0; k < 32; k++) modelPend[k] = 0;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    checkConst("reset_idle", 32'h0, 0, 0);
    setId(1, 0, 0, 0);
    setSrc(0, 1, 17, 32'hCAFE_0017);
    #1;
    checkConst("reset_rf_read", 32'hCAFE_0017, 0, 0);
    cycle();

    vecs.push_back(mkVec("fwd_ex_over_me", 3'b011, 3'b011, 5, 5, 0, 32'h11, 32'h22, 32'h0, 1, 5, 32'h99, 32'h11, 0, 3'b000));
    vecs.push_back(mkVec("load_use", 3'b001, 3'b000, 7, 0, 0, 32'h0, 32'h0, 32'h0, 1, 7, 32'h99, 32'h0, 1, 3'b001));
    vecs.push_back(mkVec("load_ready", 3'b001, 3'b001, 7, 0, 0, 32'hAB, 32'h0, 32'h0, 1, 7, 32'h99, 32'hAB, 0, 3'b000));
    vecs.push_back(mkVec("r0_ignores_fwd", 3'b001, 3'b001, 0, 0, 0, 32'hFF, 32'h0, 32'h0, 1, 0, 32'h55, 32'h0, 0, 3'b000));
    vecs.push_back(mkVec("invalid_ex_skipped", 3'b010, 3'b011, 3, 3, 0, 32'h33, 32'h44, 32'h0, 1, 3, 32'h99, 32'h44, 0, 3'b000));
    vecs.push_back(mkVec("me_unready_blocks_wb", 3'b110, 3'b100, 1, 9, 9, 32'h0, 32'h88, 32'h99, 1, 9, 32'h12, 32'h0, 1, 3'b001));
    vecs.push_back(mkVec("rf_no_match", 3'b111, 3'b111, 1, 2, 3, 32'h1, 32'h2, 32'h3, 1, 10, 32'hDEAD, 32'hDEAD, 0, 3'b000));
    vecs.push_back(mkVec("src_disabled", 3'b001, 3'b001, 5, 0, 0, 32'h11, 32'h0, 32'h0, 0, 5, 32'h99, 32'h0, 0, 3'b000));
    vecs.push_back(mkVec("wb_only", 3'b100, 3'b100, 0, 0, 12, 32'h0, 32'h0, 32'h77, 1, 12, 32'h99, 32'h77, 0, 3'b000));
    vecs.push_back(mkVec("ex_unready_hides_me", 3'b011, 3'b010, 6, 6, 0, 32'h1, 32'h2, 32'h0, 1, 6, 32'h99, 32'h0, 1, 3'b001));

    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      #1;
      checkConst(vecs[k].name, vecs[k].expV, vecs[k].expS, vecs[k].expC);
      cycle();
    end

    $display("[TB] scoreboard RAW sequence");
    clearInputs();
    setId(1, 9, 1, 1);
    #1; checkConst("issue_long9", 32'h0, 0, 3'b000); cycle();
    setId(1, 0, 0, 0);
    setSrc(0, 1, 9, 32'h1234);
    #1; checkConst("sb_raw_r9", 32'h0, 1, 3'b010); cycle();
    setLw(1, 9, 32'h5);
    #1; checkConst("lw_bypass_r9", 32'h5, 0, 3'b000); cycle();
    setLw(0, 0, 32'h0);
    #1; checkConst("r9_cleared", 32'h1234, 0, 3'b000); cycle();

    $display("[TB] WAW sequence");
    clearInputs();
    setId(1, 4, 1, 1);
    #1; checkConst("issue_long4", 32'h0, 0, 3'b000); cycle();
    setId(1, 4, 0, 0);
    #1; checkConst("waw_r4_a", 32'h0, 1, 3'b100); cycle();
    #1; checkConst("waw_r4_b", 32'h0, 1, 3'b100); cycle();
    setLw(1, 4, 32'h44);
    setId(1, 4, 0, 1);
    #1; checkConst("waw_r4_release", 32'h0, 0, 3'b000); cycle();
    setLw(0, 0, 32'h0);
    setId(1, 4, 0, 0);
    #1; checkConst("r4_free", 32'h0, 0, 3'b000); cycle();

    $display("[TB] inc and dec in one cycle");
    clearInputs();
    setId(1, 3, 1, 1);
    #1; checkConst("issue_long3", 32'h0, 0, 3'b000); cycle();
    setLw(1, 3, 32'h0);
    #1; checkConst("inc_dec_same", 32'h0, 0, 3'b000); cycle();
    setLw(0, 0, 32'h0);
    setId(1, 0, 0, 0);
    setSrc(0, 1, 3, 32'h333);
    #1; checkConst("r3_still_pending", 32'h0, 1, 3'b010); cycle();
    setLw(1, 3, 32'h3A);
    #1; checkConst("r3_retire", 32'h3A, 0, 3'b000); cycle();
    setLw(0, 0, 32'h0);
    #1; checkConst("r3_free", 32'h333, 0, 3'b000); cycle();

    $display("[TB] saturation sequence");
    clearInputs();
    for (int k = 0; k < 3; k++) begin
      setId(0, 6, 1, 1);
      #1; checkConst($sformatf("sat_issue%0d", k), 32'h0, 0, 3'b000); cycle();
    end
    setId(1, 6, 1, 0);
    setLw(1, 6, 32'h0);
    #1; checkConst("sat_waw", 32'h0, 1, 3'b100); cycle();
    setId(1, 6, 0, 0);
    #1; checkConst("sat_lw_exempt", 32'h0, 0, 3'b000); cycle();
    setId(0, 0, 0, 0);
    cycle();
    setLw(0, 0, 32'h0);
    setId(1, 0, 0, 0);
    setSrc(0, 1, 6, 32'h66);
    #1; checkConst("r6_free", 32'h66, 0, 3'b000); cycle();

    $display("[TB] reset while pending");
    clearInputs();
    setId(1, 12, 1, 1);
    cycle();
    setId(1, 0, 0, 0);
    setSrc(0, 1, 12, 32'hC);
    #1; checkConst("r12_pending", 32'h0, 1, 3'b010); cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1; checkConst("r12_after_reset", 32'hC, 0, 3'b000); cycle();

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      clearInputs();
      for (int i = 0; i < NF; i++) begin
        setFwd(i, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 3) != 0), $urandom);
      end
      for (int j = 0; j < NS; j++) begin
        setSrc(j, int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), $urandom);
      end
      setId(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 2) == 0), 0);
      r = int'($urandom_range(1, 7));
      if (modelPend[r] > 0 && $urandom_range(0, 1) == 1) setLw(1, r, $urandom);
      #1;
      modelEval();
      if (bus.id_valid && !expStall && $urandom_range(0, 1) == 1) bus.issue_fire = 1'b1;
      #1;
      checkOutput($sformatf("rand%0d", n));
      cycle();
    end

`ifdef HAZARD_STATS_EN
    compare("stat_fwd", bus.stat_fwd_stall, 32'(modelStatFwd));
    compare("stat_sb",  bus.stat_sb_stall,  32'(modelStatSb));
    compare("stat_waw", bus.stat_waw_stall, 32'(modelStatWaw));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
